// File: rtl/bicubic_coord_sched.sv
// bicubic_coord_sched
// Output-raster scheduler for the bicubic scaler. Walks the output frame in
// raster order, accumulating Q(DIM_W).FRAC_W source coordinates from per-axis
// step values, and issues one coordinate beat per output pixel under a
// valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse, begins a frame (honoured in IDLE only)
//   abort                 synchronous return to IDLE from any state
//   out_w, out_h          output frame size (sampled at start)
//   src_w, src_h          source frame size for clamping (sampled at start)
//   step_x, step_y        source increment per output pixel / line (Q12.8)
//   a_cfg                 bicubic "a" parameter (sampled at start)
//   coeff_one, coeff_half constants 256 / 128
//   bi_a                  latched a_cfg
//   x_blend, y_blend      fractional blends, forced to 0 on clamped taps
//   src_x, src_y          clamped integer source tap position
//   out_x, out_y          current output coordinate
//   sol, eol, eof         start/end of line, end of frame (qualified by valid)
//   valid, ready          beat handshake
//   busy                  high while running
//   done                  one-cycle pulse at frame end
module bicubic_coord_sched #(
    parameter int DIM_W  = 12,
    parameter int FRAC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DIM_W-1:0]        out_w,
    input  logic [DIM_W-1:0]        out_h,
    input  logic [DIM_W-1:0]        src_w,
    input  logic [DIM_W-1:0]        src_h,
    input  logic [DIM_W+FRAC_W-1:0] step_x,
    input  logic [DIM_W+FRAC_W-1:0] step_y,
    input  logic [8:0]              a_cfg,
    output logic [8:0]              coeff_one,
    output logic [8:0]              coeff_half,
    output logic [8:0]              bi_a,
    output logic [FRAC_W:0]         x_blend,
    output logic [FRAC_W:0]         y_blend,
    output logic [DIM_W-1:0]        src_x,
    output logic [DIM_W-1:0]        src_y,
    output logic [DIM_W-1:0]        out_x,
    output logic [DIM_W-1:0]        out_y,
    output logic                    sol,
    output logic                    eol,
    output logic                    eof,
    output logic                    valid,
    input  logic                    ready,
    output logic                    busy,
    output logic                    done
);

    localparam int STEP_W = DIM_W + FRAC_W;
    localparam int ACC_W  = DIM_W + FRAC_W + 1;
    localparam int INT_W  = DIM_W + 1;
    localparam int TAP_W  = DIM_W + FRAC_W + 1;

    localparam logic [DIM_W-1:0] D_ONE = 1;
    localparam logic [INT_W-1:0] I_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [ACC_W-1:0]  acc_x, acc_y, acc_x_n, acc_y_n;
    logic [DIM_W-1:0]  x_n, y_n;
    logic              load;

    logic [DIM_W-1:0]  cfg_out_w, cfg_out_h, cfg_src_w, cfg_src_h;
    logic [STEP_W-1:0] cfg_step_x, cfg_step_y;

    logic [DIM_W-1:0]  e_out_w, e_out_h, e_src_w, e_src_h;
    logic [TAP_W-1:0]  tap_x, tap_y;
    logic              valid_n, done_n, sol_n, eol_n, eof_n;

    assign coeff_one  = 9'd256;
    assign coeff_half = 9'd128;

    // Saturating accumulate: the accumulator sticks at all-ones rather than wrap.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [STEP_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {2'b00, b};
        if (s[ACC_W])
            return '1;
        return s[ACC_W-1:0];
    endfunction

    // Returns {tap, blend}. A tap at or beyond the last source sample has no
    // right-hand neighbour to blend with, so it is pinned to lim-1 with blend 0.
    function automatic logic [TAP_W-1:0] clamp_tap(input logic [ACC_W-1:0] acc,
                                                   input logic [DIM_W-1:0] lim);
        logic [INT_W-1:0] ipart;
        ipart = acc[ACC_W-1:FRAC_W];
        if (lim == '0)
            return '0;
        if (ipart >= ({1'b0, lim} - I_ONE))
            return {lim - D_ONE, {(FRAC_W+1){1'b0}}};
        return {ipart[DIM_W-1:0], 1'b0, acc[FRAC_W-1:0]};
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next-state and counter/accumulator update
    always_comb begin
        state_n = state;
        load    = 1'b0;
        x_n     = out_x;
        y_n     = out_y;
        acc_x_n = acc_x;
        acc_y_n = acc_y;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (out_w == '0 || out_h == '0) begin
                            state_n = S_DONE;
                        end else begin
                            load    = 1'b1;
                            x_n     = '0;
                            y_n     = '0;
                            acc_x_n = '0;
                            acc_y_n = '0;
                            state_n = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (ready) begin
                        if (out_x == cfg_out_w - D_ONE) begin
                            x_n     = '0;
                            acc_x_n = '0;
                            if (out_y == cfg_out_h - D_ONE) begin
                                state_n = S_DONE;
                            end else begin
                                y_n     = out_y + D_ONE;
                                acc_y_n = sat_add(acc_y, cfg_step_y);
                            end
                        end else begin
                            x_n     = out_x + D_ONE;
                            acc_x_n = sat_add(acc_x, cfg_step_x);
                        end
                    end
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Output decode from next-cycle values so every port comes straight off a
    // flop; on the start cycle the live config inputs stand in for the latches.
    always_comb begin
        e_out_w = load ? out_w : cfg_out_w;
        e_out_h = load ? out_h : cfg_out_h;
        e_src_w = load ? src_w : cfg_src_w;
        e_src_h = load ? src_h : cfg_src_h;
        valid_n = (state_n == S_RUN);
        done_n  = (state_n == S_DONE);
        tap_x   = clamp_tap(acc_x_n, e_src_w);
        tap_y   = clamp_tap(acc_y_n, e_src_h);
        sol_n   = valid_n && (x_n == '0);
        eol_n   = valid_n && (x_n == e_out_w - D_ONE);
        eof_n   = eol_n && (y_n == e_out_h - D_ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_x      <= '0;
            out_y      <= '0;
            acc_x      <= '0;
            acc_y      <= '0;
            cfg_out_w  <= '0;
            cfg_out_h  <= '0;
            cfg_src_w  <= '0;
            cfg_src_h  <= '0;
            cfg_step_x <= '0;
            cfg_step_y <= '0;
            bi_a       <= '0;
            src_x      <= '0;
            src_y      <= '0;
            x_blend    <= '0;
            y_blend    <= '0;
            sol        <= 1'b0;
            eol        <= 1'b0;
            eof        <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            out_x   <= x_n;
            out_y   <= y_n;
            acc_x   <= acc_x_n;
            acc_y   <= acc_y_n;
            if (load) begin
                cfg_out_w  <= out_w;
                cfg_out_h  <= out_h;
                cfg_src_w  <= src_w;
                cfg_src_h  <= src_h;
                cfg_step_x <= step_x;
                cfg_step_y <= step_y;
                bi_a       <= a_cfg;
            end
            src_x   <= tap_x[TAP_W-1:FRAC_W+1];
            x_blend <= tap_x[FRAC_W:0];
            src_y   <= tap_y[TAP_W-1:FRAC_W+1];
            y_blend <= tap_y[FRAC_W:0];
            sol     <= sol_n;
            eol     <= eol_n;
            eof     <= eof_n;
            valid   <= valid_n;
            busy    <= valid_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_bicubic_coord_sched.sv
module tb_bicubic_coord_sched;

    logic        clk, rst_n, start, abort, ready;
    logic [11:0] out_w, out_h, src_w, src_h;
    logic [19:0] step_x, step_y;
    logic [8:0]  a_cfg;
    logic [8:0]  coeff_one, coeff_half, bi_a, x_blend, y_blend;
    logic [11:0] src_x, src_y, out_x, out_y;
    logic        sol, eol, eof, valid, busy, done;

    int checks   = 0;
    int failures = 0;

    bicubic_coord_sched #(.DIM_W(12), .FRAC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .out_w(out_w), .out_h(out_h), .src_w(src_w), .src_h(src_h),
        .step_x(step_x), .step_y(step_y), .a_cfg(a_cfg),
        .coeff_one(coeff_one), .coeff_half(coeff_half), .bi_a(bi_a),
        .x_blend(x_blend), .y_blend(y_blend), .src_x(src_x), .src_y(src_y),
        .out_x(out_x), .out_y(out_y), .sol(sol), .eol(eol), .eof(eof),
        .valid(valid), .ready(ready), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference tap: saturated accumulator value -> {tap[11:0], blend[8:0]}
    function automatic logic [20:0] ref_tap(input longint acc, input int lim);
        longint ix;
        logic [11:0] sx;
        logic [8:0]  bl;
        if (acc > 64'd2097151) acc = 2097151;
        ix = acc >> 8;
        if (lim == 0) begin
            sx = 0; bl = 0;
        end else if (ix >= lim - 1) begin
            sx = 12'(lim - 1); bl = 0;
        end else begin
            sx = 12'(ix); bl = 9'(acc % 256);
        end
        return {sx, bl};
    endfunction

    function automatic logic [68:0] ref_beat(input int x, input int y, input int w, input int h,
                                             input int sw, input int sh, input int stx, input int sty);
        logic [20:0] tx, ty;
        logic s, e, f;
        tx = ref_tap(longint'(x) * stx, sw);
        ty = ref_tap(longint'(y) * sty, sh);
        s = (x == 0);
        e = (x == w - 1);
        f = e && (y == h - 1);
        return {12'(x), 12'(y), tx[20:9], ty[20:9], tx[8:0], ty[8:0], s, e, f};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; start = 0; abort = 0; ready = 0;
        out_w = 0; out_h = 0; src_w = 0; src_h = 0; step_x = 0; step_y = 0; a_cfg = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Runs one frame; rdy_mode 0 = ready held high, 1 = random ready.
    // start_at >= 0 pulses a (to be ignored) start with junk config at that beat.
    task automatic run_frame(input string name, input int w, input int h, input int sw, input int sh,
                             input int stx, input int sty, input int a, input int rdy_mode, input int start_at);
        logic [68:0] exp_q[$];
        logic [68:0] obs;
        int idx, cyc, budget, n;
        logic rdy, was_valid;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                exp_q.push_back(ref_beat(x, y, w, h, sw, sh, stx, sty));
        n = w * h;
        out_w = 12'(w); out_h = 12'(h); src_w = 12'(sw); src_h = 12'(sh);
        step_x = 20'(stx); step_y = 20'(sty); a_cfg = 9'(a);
        ready = (rdy_mode == 0);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        // config must have been captured at start only
        out_w = 12'($urandom); out_h = 12'($urandom); src_w = 12'($urandom); src_h = 12'($urandom);
        step_x = 20'($urandom); step_y = 20'($urandom); a_cfg = 9'($urandom);
        checks++;
        if (bi_a !== 9'(a)) begin
            failures++;
            $display("FAIL %s bi_a: got %0d expected %0d", name, bi_a, a);
        end
        idx = 0; cyc = 0; budget = n * 6 + 20;
        while (idx < n && cyc < budget) begin
            checks++;
            if (valid !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s valid/busy at beat %0d: got %b%b expected 11", name, idx, valid, busy);
                break;
            end
            obs = {out_x, out_y, src_x, src_y, x_blend, y_blend, sol, eol, eof};
            if (obs !== exp_q[idx]) begin
                failures++;
                $display("FAIL %s beat %0d: got %h expected %h", name, idx, obs, exp_q[idx]);
            end
            start = (idx == start_at);
            rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom % 2);
            ready = rdy;
            was_valid = valid;
            @(posedge clk); #1;
            cyc++;
            if (was_valid && rdy) idx++;
        end
        start = 0;
        ready = 1;
        checks++;
        if (idx != n) begin
            failures++;
            $display("FAIL %s beats: got %0d expected %0d", name, idx, n);
        end else begin
            if ({done, valid} !== 2'b10) begin
                failures++;
                $display("FAIL %s done after last beat: got done,valid=%b%b expected 10", name, done, valid);
            end
            @(posedge clk); #1;
            checks++;
            if ({done, valid, busy} !== 3'b000) begin
                failures++;
                $display("FAIL %s done pulse end: got %b%b%b expected 000", name, done, valid, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; abort = 0; ready = 0;
        #3;
        checks++;
        if ({valid, busy, done, sol, eol, eof} !== 6'b0) begin
            failures++;
            $display("FAIL reset flags: got %b expected 000000", {valid, busy, done, sol, eol, eof});
        end
        checks++;
        if ({coeff_one, coeff_half, bi_a} !== {9'd256, 9'd128, 9'd0}) begin
            failures++;
            $display("FAIL reset consts: got %0d %0d %0d expected 256 128 0", coeff_one, coeff_half, bi_a);
        end
        checks++;
        if ({out_x, out_y, src_x, src_y, x_blend, y_blend} !== 66'b0) begin
            failures++;
            $display("FAIL reset coords: got %h expected 0", {out_x, out_y, src_x, src_y, x_blend, y_blend});
        end
        do_reset();
    endtask

    task automatic test_identity();
        run_frame("identity", 4, 2, 4, 2, 256, 256, 9'h1a5, 0, -1);
    endtask

    task automatic test_upscale();
        run_frame("upscale", 4, 2, 2, 2, 128, 256, 9'h0f0, 0, -1);
    endtask

    task automatic test_backpressure();
        run_frame("bp_identity", 4, 2, 4, 2, 256, 256, 9'h033, 1, -1);
        run_frame("bp_upscale", 4, 2, 2, 2, 128, 256, 9'h044, 1, -1);
    endtask

    task automatic test_zero_size();
        for (int k = 0; k < 2; k++) begin
            out_w = (k == 0) ? 12'd5 : 12'd0;
            out_h = (k == 0) ? 12'd0 : 12'd3;
            ready = 1; start = 1;
            @(posedge clk); #1;
            start = 0;
            checks++;
            if ({done, valid} !== 2'b10) begin
                failures++;
                $display("FAIL zero_size %0d done: got done,valid=%b%b expected 10", k, done, valid);
            end
            @(posedge clk); #1;
            checks++;
            if ({done, valid} !== 2'b00) begin
                failures++;
                $display("FAIL zero_size %0d after: got done,valid=%b%b expected 00", k, done, valid);
            end
        end
    endtask

    task automatic test_abort();
        out_w = 8; out_h = 4; src_w = 8; src_h = 4; step_x = 256; step_y = 256; a_cfg = 1;
        ready = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) begin @(posedge clk); #1; end
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        checks++;
        if ({valid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL abort: got valid,busy,done=%b%b%b expected 000", valid, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({valid, done} !== 2'b00) begin
                failures++;
                $display("FAIL abort idle %0d: got valid,done=%b%b expected 00", i, valid, done);
            end
        end
        // abort beats start in IDLE
        abort = 1; start = 1;
        @(posedge clk); #1;
        abort = 0; start = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({valid, busy, done} !== 3'b000) begin
                failures++;
                $display("FAIL abort_start %0d: got %b%b%b expected 000", i, valid, busy, done);
            end
            @(posedge clk); #1;
        end
        run_frame("restart", 3, 2, 3, 2, 256, 256, 9'h055, 0, -1);
    endtask

    task automatic test_start_during_run();
        run_frame("start_in_run", 3, 3, 5, 5, 300, 200, 9'h066, 1, 2);
    endtask

    task automatic test_async_reset();
        logic was;
        out_w = 6; out_h = 3; src_w = 6; src_h = 3; step_x = 256; step_y = 256; a_cfg = 9'h1ff;
        ready = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) begin @(posedge clk); #1; end
        was = valid;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({was, valid, busy, done, out_x, src_x, x_blend, bi_a} !== {1'b1, 3'b000, 12'd0, 12'd0, 9'd0, 9'd0}) begin
            failures++;
            $display("FAIL async_reset: got prev_valid=%b valid=%b busy=%b done=%b out_x=%0d src_x=%0d xb=%0d bi_a=%0d",
                     was, valid, busy, done, out_x, src_x, x_blend, bi_a);
        end
        checks++;
        if ({coeff_one, coeff_half} !== {9'd256, 9'd128}) begin
            failures++;
            $display("FAIL async_reset consts: got %0d %0d expected 256 128", coeff_one, coeff_half);
        end
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if ({valid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset idle: got %b%b%b expected 000", valid, busy, done);
        end
        run_frame("after_reset", 4, 2, 4, 2, 256, 256, 9'h011, 0, -1);
    endtask

    task automatic test_random();
        int w, h, sw, sh, stx, sty;
        for (int f = 0; f < 8; f++) begin
            w = $urandom_range(1, 6); h = $urandom_range(1, 4);
            sw = $urandom_range(0, 8); sh = $urandom_range(0, 8);
            case ($urandom % 4)
                0: stx = $urandom_range(0, 768);
                1: stx = 256;
                2: stx = 1048575 - $urandom_range(0, 15);
                default: stx = $urandom_range(0, 1048575);
            endcase
            case ($urandom % 3)
                0: sty = $urandom_range(0, 768);
                1: sty = 1048575;
                default: sty = $urandom_range(0, 1048575);
            endcase
            run_frame($sformatf("random%0d", f), w, h, sw, sh, stx, sty, $urandom_range(0, 511), 1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_upscale();
        test_backpressure();
        test_zero_size();
        test_abort();
        test_start_during_run();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
